// File: rtl/dec_3to8_strobe_pkg.sv
// Shared state encoding and sizing helpers for the strobe decoder.
package dec_pkg;

  // Controller states. The fourth encoding is unreachable in normal operation
  // and is steered back to IDLE by the next-state logic.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    BAD   = 2'd3
  } state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter must hold the largest reload value (phase length - 1) without wrap.
  function automatic int cnt_width(input int pulse_cycles, input int gap_cycles);
    return $clog2(max2(pulse_cycles, gap_cycles) + 1);
  endfunction

endpackage

// File: rtl/dec_3to8_strobe_bin_to_onehot.sv
// Combinational binary code to one-hot decoder.
module bin_to_onehot #(
  parameter int IN_W = 3
) (
  input  logic [IN_W-1:0]      code_i,
  output logic [(1<<IN_W)-1:0] onehot_o
);

  // Exactly one bit set, selected by the code.
  always_comb begin
    onehot_o         = '0;
    onehot_o[code_i] = 1'b1;
  end

endmodule

// File: rtl/dec_3to8_strobe.sv
// Registered binary-to-one-hot strobe generator with valid/ready intake.
// Each accepted code produces a PULSE_CYCLES-long one-hot strobe followed by
// GAP_CYCLES idle cycles; a new code may be taken in the final cycle.
//
//   state | meaning
//   ------+--------------------------------------------------
//   IDLE  | output low, ready for a code
//   PULSE | one-hot strobe driven, cnt counts remaining cycles
//   GAP   | output low, cnt counts remaining gap cycles
//   BAD   | unreachable encoding, returns to IDLE
module dec_3to8_strobe
  import dec_pkg::*;
#(
  parameter int IN_W         = 3,
  parameter int PULSE_CYCLES = 1,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_W-1:0]       in_code,
  output logic [(1<<IN_W)-1:0]  out_onehot,
  output logic                  out_active,
  output logic                  busy
);

  localparam int OUT_W   = 1 << IN_W;
  localparam int CNT_W   = cnt_width(PULSE_CYCLES, GAP_CYCLES);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [OUT_W-1:0]   onehot_q, onehot_d;
  logic [OUT_W-1:0]   code_onehot;
  logic               cnt_zero;
  logic               accept;

  bin_to_onehot #(.IN_W(IN_W)) u_dec (
    .code_i   (in_code),
    .onehot_o (code_onehot)
  );

  assign cnt_zero = (cnt_q == '0);
  assign accept   = in_valid & in_ready;

  // Ready depends only on state and count: idle, or the last cycle of the final phase.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = 1'b1;
      PULSE:   in_ready = cnt_zero & ~HAS_GAP;
      GAP:     in_ready = cnt_zero;
      default: in_ready = 1'b0;
    endcase
  end

  // Next-state, counter and strobe register inputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    onehot_d = onehot_q;
    case (state_q)
      IDLE: begin
        onehot_d = '0;
        if (accept) begin
          state_d  = PULSE;
          cnt_d    = PULSE_LOAD;
          onehot_d = code_onehot;
        end
      end
      PULSE: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (HAS_GAP) begin
          state_d  = GAP;
          cnt_d    = GAP_LOAD;
          onehot_d = '0;
        end else if (accept) begin
          state_d  = PULSE;
          cnt_d    = PULSE_LOAD;
          onehot_d = code_onehot;
        end else begin
          state_d  = IDLE;
          cnt_d    = '0;
          onehot_d = '0;
        end
      end
      GAP: begin
        onehot_d = '0;
        if (!cnt_zero) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (accept) begin
          state_d  = PULSE;
          cnt_d    = PULSE_LOAD;
          onehot_d = code_onehot;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        onehot_d = '0;
      end
    endcase
  end

  // State, counter and strobe registers; reset clears outputs without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
    end
  end

  assign out_onehot = onehot_q;
  assign out_active = |onehot_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dec_3to8_strobe.sv
// Bench for dec_3to8_strobe: three parameterisations side by side, directed
// scenarios plus a randomized run against a timestamp-based reference model.
module tb_dec_3to8_strobe;

  localparam int NI = 3;
  localparam int PP [NI] = '{1, 3, 4};
  localparam int GG [NI] = '{0, 2, 1};

  logic       clk;
  logic       rst_n;
  logic       valid [NI];
  logic [2:0] code  [NI];
  logic [7:0] oh    [NI];
  logic       act   [NI];
  logic       rdy   [NI];
  logic       bsy   [NI];

  int tests_run;
  int failed;

  dec_3to8_strobe #(.IN_W(3), .PULSE_CYCLES(1), .GAP_CYCLES(0)) u_p1g0 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid[0]), .in_ready(rdy[0]),
    .in_code(code[0]), .out_onehot(oh[0]), .out_active(act[0]), .busy(bsy[0]));

  dec_3to8_strobe #(.IN_W(3), .PULSE_CYCLES(3), .GAP_CYCLES(2)) u_p3g2 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid[1]), .in_ready(rdy[1]),
    .in_code(code[1]), .out_onehot(oh[1]), .out_active(act[1]), .busy(bsy[1]));

  dec_3to8_strobe #(.IN_W(3), .PULSE_CYCLES(4), .GAP_CYCLES(1)) u_p4g1 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid[2]), .in_ready(rdy[2]),
    .in_code(code[2]), .out_onehot(oh[2]), .out_active(act[2]), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < NI; i++) valid[i] = 1'b0;
    repeat (10) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      valid[i] = 1'b0;
      code[i]  = 3'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      tests_run++;
      if (oh[i] !== 8'h00) begin
        failed++; $display("FAIL reset_onehot inst%0d got %h want 00", i, oh[i]);
      end
      tests_run++;
      if (act[i] !== 1'b0) begin
        failed++; $display("FAIL reset_active inst%0d got %b want 0", i, act[i]);
      end
      tests_run++;
      if (rdy[i] !== 1'b1) begin
        failed++; $display("FAIL reset_ready inst%0d got %b want 1", i, rdy[i]);
      end
      tests_run++;
      if (bsy[i] !== 1'b0) begin
        failed++; $display("FAIL reset_busy inst%0d got %b want 0", i, bsy[i]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stream_p1g0();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) begin
      tests_run++;
      if (rdy[0] !== 1'b1) begin
        failed++; $display("FAIL stream_ready code%0d got %b want 1", i, rdy[0]);
      end
      valid[0] = 1'b1;
      code[0]  = 3'(i);
      tick();
      exp = 8'd1 << i;
      tests_run++;
      if (oh[0] !== exp) begin
        failed++; $display("FAIL stream_onehot code%0d got %h want %h", i, oh[0], exp);
      end
      tests_run++;
      if (act[0] !== 1'b1) begin
        failed++; $display("FAIL stream_active code%0d got %b want 1", i, act[0]);
      end
    end
    valid[0] = 1'b0;
    tick();
    tests_run++;
    if (oh[0] !== 8'h00 || bsy[0] !== 1'b0) begin
      failed++; $display("FAIL stream_end got oh=%h busy=%b want 00/0", oh[0], bsy[0]);
    end
  endtask

  task automatic test_pulse_gap();
    logic [7:0] exp_oh [5];
    logic       exp_rd [5];
    exp_oh = '{8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
    exp_rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    valid[1] = 1'b1;
    code[1]  = 3'd5;
    tick();
    code[1] = 3'd3;
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (oh[1] !== exp_oh[k]) begin
        failed++; $display("FAIL pg_onehot cyc%0d got %h want %h", k, oh[1], exp_oh[k]);
      end
      tests_run++;
      if (rdy[1] !== exp_rd[k]) begin
        failed++; $display("FAIL pg_ready cyc%0d got %b want %b", k, rdy[1], exp_rd[k]);
      end
      tests_run++;
      if (bsy[1] !== 1'b1) begin
        failed++; $display("FAIL pg_busy cyc%0d got %b want 1", k, bsy[1]);
      end
      tick();
    end
    tests_run++;
    if (oh[1] !== 8'h08) begin
      failed++; $display("FAIL pg_second_code got %h want 08", oh[1]);
    end
    valid[1] = 1'b0;
    repeat (5) tick();
    tests_run++;
    if (bsy[1] !== 1'b0 || oh[1] !== 8'h00) begin
      failed++; $display("FAIL pg_idle got busy=%b oh=%h want 0/00", bsy[1], oh[1]);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_oh [6];
    logic       exp_rd [5];
    exp_oh = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h40};
    exp_rd = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    valid[2] = 1'b1;
    code[2]  = 3'd1;
    tick();
    code[2] = 3'd2;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) code[2] = 3'd6;
      tests_run++;
      if (oh[2] !== exp_oh[k]) begin
        failed++; $display("FAIL bp_onehot cyc%0d got %h want %h", k, oh[2], exp_oh[k]);
      end
      if (k < 5) begin
        tests_run++;
        if (rdy[2] !== exp_rd[k]) begin
          failed++; $display("FAIL bp_ready cyc%0d got %b want %b", k, rdy[2], exp_rd[k]);
        end
        tick();
      end
    end
    valid[2] = 1'b0;
    repeat (6) tick();
    tests_run++;
    if (bsy[2] !== 1'b0) begin
      failed++; $display("FAIL bp_idle got busy=%b want 0", bsy[2]);
    end
  endtask

  task automatic test_async_reset();
    valid[1] = 1'b1;
    code[1]  = 3'd4;
    tick();
    valid[1] = 1'b0;
    tick();
    tests_run++;
    if (oh[1] !== 8'h10) begin
      failed++; $display("FAIL ar_pre got %h want 10", oh[1]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (oh[1] !== 8'h00 || act[1] !== 1'b0) begin
      failed++; $display("FAIL ar_clear got oh=%h act=%b want 00/0", oh[1], act[1]);
    end
    tests_run++;
    if (bsy[1] !== 1'b0 || rdy[1] !== 1'b1) begin
      failed++; $display("FAIL ar_state got busy=%b ready=%b want 0/1", bsy[1], rdy[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    valid[1] = 1'b1;
    code[1]  = 3'd7;
    tick();
    valid[1] = 1'b0;
    tests_run++;
    if (oh[1] !== 8'h80) begin
      failed++; $display("FAIL ar_after got %h want 80", oh[1]);
    end
    drain();
  endtask

  task automatic test_final_cycle();
    valid[1] = 1'b1;
    code[1]  = 3'd3;
    tick();
    valid[1] = 1'b0;
    repeat (4) tick();
    tests_run++;
    if (rdy[1] !== 1'b1 || oh[1] !== 8'h00) begin
      failed++; $display("FAIL fc_last_gap got ready=%b oh=%h want 1/00", rdy[1], oh[1]);
    end
    tick();
    tests_run++;
    if (bsy[1] !== 1'b0 || rdy[1] !== 1'b1 || oh[1] !== 8'h00) begin
      failed++; $display("FAIL fc_idle got busy=%b ready=%b oh=%h want 0/1/00", bsy[1], rdy[1], oh[1]);
    end
    valid[1] = 1'b1;
    code[1]  = 3'd1;
    tick();
    valid[1] = 1'b0;
    tests_run++;
    if (oh[1] !== 8'h02) begin
      failed++; $display("FAIL fc_late_code got %h want 02", oh[1]);
    end
    drain();
  endtask

  // Reference: each instance is busy for P+G cycles after an accept edge; the
  // strobe shows for the first P of them and ready rises in the last one.
  task automatic test_random(input int ncyc);
    longint     n;
    longint     acc_edge [NI];
    logic [2:0] acc_code [NI];
    logic       take     [NI];
    longint     e;
    logic [7:0] exp_oh;
    logic       exp_rd, exp_bs;
    n = 0;
    for (int i = 0; i < NI; i++) begin
      acc_edge[i] = -1000;
      acc_code[i] = 3'd0;
    end
    for (int c = 0; c < ncyc; c++) begin
      for (int i = 0; i < NI; i++) begin
        e      = n - acc_edge[i];
        exp_oh = (e < PP[i]) ? (8'd1 << acc_code[i]) : 8'h00;
        exp_rd = (e >= PP[i] + GG[i] - 1);
        exp_bs = (e < PP[i] + GG[i]);
        tests_run++;
        if (oh[i] !== exp_oh || act[i] !== (exp_oh != 8'h00) ||
            rdy[i] !== exp_rd || bsy[i] !== exp_bs) begin
          failed++;
          $display("FAIL rnd inst%0d cyc%0d got oh=%h act=%b rdy=%b busy=%b want %h/%b/%b/%b",
                   i, c, oh[i], act[i], rdy[i], bsy[i], exp_oh, exp_oh != 8'h00, exp_rd, exp_bs);
        end
        valid[i] = ($urandom_range(0, 3) != 0);
        code[i]  = 3'($urandom_range(0, 7));
        take[i]  = valid[i] && exp_rd;
      end
      tick();
      n++;
      for (int i = 0; i < NI; i++) begin
        if (take[i]) begin
          acc_edge[i] = n;
          acc_code[i] = code[i];
        end
      end
    end
    drain();
  endtask

  initial begin
    tests_run = 0;
    failed    = 0;
    rst_n     = 1'b0;
    for (int i = 0; i < NI; i++) begin
      valid[i] = 1'b0;
      code[i]  = 3'd0;
    end
    test_reset();
    test_stream_p1g0();
    test_pulse_gap();
    test_backpressure();
    test_async_reset();
    test_final_cycle();
    test_random(400);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
